// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file responder: FSM encoding,
// request direction codes and default geometry.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DEF_DW = 4;
  localparam int DEF_AW = 2;

endpackage

// File: rtl/regfile_array.sv
// Word storage plus per-word "written" flags; synchronous write and clear,
// combinational read.
module regfile_array
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          rwritten
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    words [DEPTH];
  logic [DEPTH-1:0] written_bits;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DW-1:0] word_reg;
      logic          written_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg    <= '0;
          written_reg <= 1'b0;
        end else if (we && (waddr == AW'(gi))) begin
          word_reg    <= wdata;
          written_reg <= 1'b1;
        end
      end

      assign words[gi]        = word_reg;
      assign written_bits[gi] = written_reg;
    end
  endgenerate

  assign rdata    = words[raddr];
  assign rwritten = written_bits[raddr];

endmodule

// File: rtl/regfile_responder.sv
// Request/acknowledge front end for the register file: latches one request
// from IDLE, applies the read wait, and reports completion with ack/err.
module regfile_responder
  import regfile_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = 1,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rwb,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] dbus,
  output logic [DW-1:0] qout,
  output logic          ack,
  output logic          err,
  output logic          busy,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] rd_count
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;
  logic [2:0]    wait_reg;
  logic [DW-1:0] qout_reg;
  logic          ack_reg;
  logic          err_reg;
  logic [CW-1:0] wr_count_reg;
  logic [CW-1:0] rd_count_reg;

  logic [DW-1:0] arr_rdata;
  logic          arr_written;
  logic          arr_we;

  assign arr_we = (state_reg == WRITE);

  regfile_array #(
    .DW(DW),
    .AW(AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (arr_we),
    .waddr   (addr_reg),
    .wdata   (data_reg),
    .raddr   (addr_reg),
    .rdata   (arr_rdata),
    .rwritten(arr_written)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = (rwb == RW_WRITE) ? WRITE : RWAIT;
      WRITE:   state_next = IDLE;
      RWAIT:   if (wait_reg == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      wait_reg     <= '0;
      qout_reg     <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      // ack/err default low so they pulse only on the completion cycle
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg <= address;
            wait_reg <= LAT;
            if (rwb == RW_WRITE) data_reg <= dbus;
          end
        end
        WRITE: begin
          ack_reg      <= 1'b1;
          wr_count_reg <= wr_count_reg + 1'b1;
        end
        RWAIT: begin
          if (wait_reg != 3'd0) wait_reg <= wait_reg - 3'd1;
        end
        RESP: begin
          qout_reg     <= arr_rdata;
          ack_reg      <= 1'b1;
          err_reg      <= ~arr_written;
          rd_count_reg <= rd_count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign qout     = qout_reg;
  assign ack      = ack_reg;
  assign err      = err_reg;
  assign busy     = (state_reg != IDLE);
  assign wr_count = wr_count_reg;
  assign rd_count = rd_count_reg;

endmodule

// File: tb/tb_regfile_responder.sv
// Directed bench: three responders share one stimulus bus (RD_LAT=1, RD_LAT=3,
// and CW=2); each scenario checks the instance it is aimed at.
module tb_regfile_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       rwb = 1'b0;
  logic [1:0] address = 2'b00;
  logic [3:0] dbus = 4'b0000;

  logic [3:0] qout_a, qout_b, qout_c;
  logic       ack_a, ack_b, ack_c;
  logic       err_a, err_b, err_c;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] wr_count_a, rd_count_a, wr_count_b, rd_count_b;
  logic [1:0] wr_count_c, rd_count_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_responder #(.DW(4), .AW(2), .RD_LAT(1), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .req(req), .rwb(rwb), .address(address), .dbus(dbus),
    .qout(qout_a), .ack(ack_a), .err(err_a), .busy(busy_a),
    .wr_count(wr_count_a), .rd_count(rd_count_a));

  regfile_responder #(.DW(4), .AW(2), .RD_LAT(3), .CW(8)) dut_b (
    .clk(clk), .reset(reset), .req(req), .rwb(rwb), .address(address), .dbus(dbus),
    .qout(qout_b), .ack(ack_b), .err(err_b), .busy(busy_b),
    .wr_count(wr_count_b), .rd_count(rd_count_b));

  regfile_responder #(.DW(4), .AW(2), .RD_LAT(1), .CW(2)) dut_c (
    .clk(clk), .reset(reset), .req(req), .rwb(rwb), .address(address), .dbus(dbus),
    .qout(qout_c), .ack(ack_c), .err(err_c), .busy(busy_c),
    .wr_count(wr_count_c), .rd_count(rd_count_c));

  function automatic logic sel_ack(input int sel);
    if (sel == 0) return ack_a;
    else if (sel == 1) return ack_b;
    else return ack_c;
  endfunction

  task automatic apply_reset();
    req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Presents one request for exactly the sampling edge, then drops req.
  task automatic issue(input logic rw, input logic [1:0] a, input logic [3:0] d);
    req = 1'b1; rwb = rw; address = a; dbus = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Returns the number of edges after the sample edge until ack; 0 on timeout.
  task automatic wait_ack(input int sel, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sel_ack(sel)) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout dut=%0d: no ack within 20 edges", sel);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (qout_a !== 4'b0000) begin n_bad++; $display("FAIL reset_qout: got %b want 0000", qout_a); end
    n_cmp++; if ({ack_a, err_a, busy_a} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got ack/err/busy %b want 000", {ack_a, err_a, busy_a}); end
    n_cmp++; if ({wr_count_a, rd_count_a} !== 16'h0000) begin n_bad++; $display("FAIL reset_counts: got wr=%0d rd=%0d want 0/0", wr_count_a, rd_count_a); end
    $display("reset: qout=%b ack=%b err=%b busy=%b wr=%0d rd=%0d", qout_a, ack_a, err_a, busy_a, wr_count_a, rd_count_a);
  endtask

  task automatic test_unwritten_read();
    int lat;
    issue(1'b0, 2'b00, 4'b1111);
    wait_ack(0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL unwritten_latency: got %0d edges want 3", lat); end
    n_cmp++; if (qout_a !== 4'b0000) begin n_bad++; $display("FAIL unwritten_qout: got %b want 0000", qout_a); end
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL unwritten_err: got %b want 1", err_a); end
    n_cmp++; if (rd_count_a !== 8'd1) begin n_bad++; $display("FAIL unwritten_rdcount: got %0d want 1", rd_count_a); end
    @(posedge clk); #1;
    n_cmp++; if ({ack_a, err_a} !== 2'b00) begin n_bad++; $display("FAIL pulse_width: got ack/err %b want 00", {ack_a, err_a}); end
    $display("read  a=00 lat=%0d qout=%b err=%b rd=%0d", lat, qout_a, err_a, rd_count_a);
  endtask

  task automatic test_write_read();
    logic [3:0] vals [4];
    int lat;
    vals[0] = 4'b0000; vals[1] = 4'b0101; vals[2] = 4'b1010; vals[3] = 4'b1111;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'(i), vals[i]);
      wait_ack(0, lat);
      n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL write_err a=%0d: got %b want 0", i, err_a); end
      $display("write a=%0d d=%b lat=%0d", i, vals[i], lat);
      issue(1'b0, 2'(i), ~vals[i]);
      wait_ack(0, lat);
      n_cmp++; if (qout_a !== vals[i] || err_a !== 1'b0) begin n_bad++; $display("FAIL raw_read a=%0d: got qout=%b err=%b want %b/0", i, qout_a, err_a, vals[i]); end
      $display("read  a=%0d lat=%0d qout=%b err=%b", i, lat, qout_a, err_a);
    end
    n_cmp++; if (wr_count_a !== 8'd4 || rd_count_a !== 8'd4) begin n_bad++; $display("FAIL counts_after_4: got wr=%0d rd=%0d want 4/4", wr_count_a, rd_count_a); end
  endtask

  task automatic test_overwrite();
    int lat;
    issue(1'b1, 2'b01, 4'b0011);
    wait_ack(0, lat);
    n_cmp++; if (qout_a !== 4'b1111) begin n_bad++; $display("FAIL qout_hold_on_write: got %b want 1111", qout_a); end
    $display("write a=01 d=0011 lat=%0d qout_held=%b", lat, qout_a);
    issue(1'b0, 2'b01, 4'b0000);
    wait_ack(0, lat);
    n_cmp++; if (qout_a !== 4'b0011 || err_a !== 1'b0) begin n_bad++; $display("FAIL overwrite_read: got qout=%b err=%b want 0011/0", qout_a, err_a); end
    $display("read  a=01 lat=%0d qout=%b err=%b", lat, qout_a, err_a);
    issue(1'b0, 2'b10, 4'b0000);
    wait_ack(0, lat);
    n_cmp++; if (qout_a !== 4'b1010 || err_a !== 1'b0) begin n_bad++; $display("FAIL read_10: got qout=%b err=%b want 1010/0", qout_a, err_a); end
    $display("read  a=10 lat=%0d qout=%b err=%b", lat, qout_a, err_a);
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    issue(1'b1, 2'b10, 4'b0110);
    wait_ack(0, lat);
    $display("write a=10 d=0110 lat=%0d", lat);
    // Next request is presented in the ack cycle itself
    issue(1'b1, 2'b01, 4'b1001);
    wait_ack(0, lat);
    n_cmp++; if (lat + 1 !== 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d edges between acks want 2", lat + 1); end
    $display("write a=01 d=1001 edges_between_acks=%0d", lat + 1);
    issue(1'b0, 2'b10, 4'b0000);
    wait_ack(0, lat);
    n_cmp++; if (lat !== 3 || qout_a !== 4'b0110) begin n_bad++; $display("FAIL b2b_read_10: got lat=%0d qout=%b want 3/0110", lat, qout_a); end
    $display("read  a=10 lat=%0d qout=%b", lat, qout_a);
    issue(1'b0, 2'b01, 4'b0000);
    wait_ack(0, lat);
    n_cmp++; if (qout_a !== 4'b1001 || wr_count_a !== 8'd2 || rd_count_a !== 8'd2) begin n_bad++; $display("FAIL b2b_read_01: got qout=%b wr=%0d rd=%0d want 1001/2/2", qout_a, wr_count_a, rd_count_a); end
    $display("read  a=01 lat=%0d qout=%b wr=%0d rd=%0d", lat, qout_a, wr_count_a, rd_count_a);
  endtask

  task automatic test_hold_req();
    int acks, first, busy_low;
    logic err_seen;
    apply_reset();
    acks = 0; first = 0; busy_low = 0; err_seen = 1'b0;
    req = 1'b1; rwb = 1'b0; address = 2'b10; dbus = 4'b0000;
    @(posedge clk); #1;
    for (int e = 1; e <= 10; e++) begin
      if (e <= 5 && busy_b !== 1'b1) busy_low++;
      @(posedge clk); #1;
      if (ack_b) begin
        acks++;
        if (first == 0) begin first = e; err_seen = err_b; end
      end
    end
    req = 1'b0;
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL hold_ack_count: got %0d acks want 1", acks); end
    n_cmp++; if (first !== 5) begin n_bad++; $display("FAIL hold_latency: got %0d edges want 5", first); end
    n_cmp++; if (busy_low !== 0) begin n_bad++; $display("FAIL hold_busy: got %0d cycles not busy want 0", busy_low); end
    n_cmp++; if (err_seen !== 1'b1 || qout_b !== 4'b0000) begin n_bad++; $display("FAIL hold_data: got err=%b qout=%b want 1/0000", err_seen, qout_b); end
    $display("hold  a=10 acks=%0d lat=%0d err=%b qout=%b", acks, first, err_seen, qout_b);
  endtask

  task automatic test_reset_in_rwait();
    int lat, late_acks;
    apply_reset();
    issue(1'b1, 2'b11, 4'b1111);
    wait_ack(0, lat);
    issue(1'b0, 2'b11, 4'b0000);
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rwait_busy: got %b want 1", busy_a); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if ({ack_a, err_a, busy_a, qout_a} !== 7'b0) begin n_bad++; $display("FAIL rwait_reset_out: got ack=%b err=%b busy=%b qout=%b want all 0", ack_a, err_a, busy_a, qout_a); end
    n_cmp++; if (wr_count_a !== 8'd0 || rd_count_a !== 8'd0) begin n_bad++; $display("FAIL rwait_reset_cnt: got wr=%0d rd=%0d want 0/0", wr_count_a, rd_count_a); end
    late_acks = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (ack_a) late_acks++;
    end
    n_cmp++; if (late_acks !== 0) begin n_bad++; $display("FAIL dropped_req_ack: got %0d acks want 0", late_acks); end
    $display("reset in RWAIT: late_acks=%0d", late_acks);
    issue(1'b0, 2'b11, 4'b0000);
    wait_ack(0, lat);
    n_cmp++; if (err_a !== 1'b1 || qout_a !== 4'b0000) begin n_bad++; $display("FAIL post_reset_read: got err=%b qout=%b want 1/0000", err_a, qout_a); end
    $display("read  a=11 lat=%0d qout=%b err=%b", lat, qout_a, err_a);
  endtask

  task automatic test_wrap();
    int lat;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 2'(i), 4'(i + 3));
      wait_ack(2, lat);
      $display("write a=%0d d=%b wr_c=%0d", i % 4, 4'(i + 3), wr_count_c);
    end
    n_cmp++; if (wr_count_c !== 2'd1) begin n_bad++; $display("FAIL wrap_cw2: got %0d want 1", wr_count_c); end
    n_cmp++; if (wr_count_a !== 8'd5) begin n_bad++; $display("FAIL nowrap_cw8: got %0d want 5", wr_count_a); end
  endtask

  initial begin
    test_reset();
    test_unwritten_read();
    test_write_read();
    test_overwrite();
    test_back_to_back();
    test_hold_req();
    test_reset_in_rwait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
